// File: rtl/v_alu_pkg.sv
// Opcodes, FSM state encoding and opcode-to-latency helper shared by the vector ALU scheduler.
package v_alu_pkg;

  localparam int VALU_OP_NOP  = 0;
  localparam int VALU_OP_VADD = 1;
  localparam int VALU_OP_VMUL = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Zero marks an opcode the ALU does not execute (NOP or undefined).
  function automatic int op_lat(input int op, input int add_lat, input int mul_lat);
    case (op)
      VALU_OP_VADD: return add_lat;
      VALU_OP_VMUL: return mul_lat;
      default:      return 0;
    endcase
  endfunction

endpackage

// File: rtl/v_alu_sched_arb.sv
// Combinational round-robin arbiter: first requester at or above ptr wins, otherwise the lowest one.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
    // wrapped search below the pointer
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/v_alu_sched.sv
// Round-robin issue of VADD/VMUL to one shared vector ALU; result after LAT(op)+1 cycles from grant.
// One op in flight; writeback holds in DONE until wb_ready_i, with same-cycle regrant on handshake.
module v_alu_sched
  import v_alu_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int VALUOP_DW = 5,
  parameter int VREG_DW   = 256,
  parameter int VREG_AW   = 5,
  parameter int ADD_LAT   = 1,
  parameter int MUL_LAT   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid_i,
  output logic [NREQ-1:0]               req_ready_o,
  input  logic [NREQ*VALUOP_DW-1:0]     req_op_i,
  input  logic [NREQ*VREG_DW-1:0]       req_v1_i,
  input  logic [NREQ*VREG_DW-1:0]       req_v2_i,
  input  logic [NREQ*VREG_AW-1:0]       req_wa_i,
  output logic [VALUOP_DW-1:0]          alu_op_o,
  output logic [VREG_DW-1:0]            alu_v1_o,
  output logic [VREG_DW-1:0]            alu_v2_o,
  input  logic [VREG_DW-1:0]            alu_result_i,
  output logic                          wb_valid_o,
  input  logic                          wb_ready_i,
  output logic [VREG_AW-1:0]            wb_wa_o,
  output logic [$clog2(NREQ)-1:0]       wb_src_o,
  output logic [VREG_DW-1:0]            wb_data_o,
  output logic                          busy_o
);

  localparam int SW      = $clog2(NREQ);
  localparam int LAT_MAX = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX + 1) : 1;

  state_t         state;
  logic [SW-1:0]  rr_ptr;
  logic [CW-1:0]  cnt;

  logic           win;
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] gnt;
  logic [SW-1:0]  gnt_idx;
  logic           any_gnt;
  logic           op_ok;
  logic           start;

  logic [VALUOP_DW-1:0] op_arr [NREQ];
  logic [VREG_DW-1:0]   v1_arr [NREQ];
  logic [VREG_DW-1:0]   v2_arr [NREQ];
  logic [VREG_AW-1:0]   wa_arr [NREQ];
  logic [VALUOP_DW-1:0] gnt_op;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i] = req_op_i[i*VALUOP_DW +: VALUOP_DW];
      v1_arr[i] = req_v1_i[i*VREG_DW +: VREG_DW];
      v2_arr[i] = req_v2_i[i*VREG_DW +: VREG_DW];
      wa_arr[i] = req_wa_i[i*VREG_AW +: VREG_AW];
    end
  end

  // A finishing writeback reopens the grant window in the same cycle so the ALU sees no bubble.
  assign win     = (state == IDLE) || ((state == DONE) && wb_ready_i);
  assign arb_req = req_valid_i & {NREQ{win}};

  rr_arbiter #(
    .N  (NREQ),
    .IW (SW)
  ) u_arb (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign req_ready_o = gnt;
  assign any_gnt     = |gnt;
  assign gnt_op      = op_arr[gnt_idx];
  assign op_ok       = op_lat(int'(gnt_op), ADD_LAT, MUL_LAT) != 0;
  assign start       = any_gnt && op_ok;
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      alu_op_o   <= '0;
      alu_v1_o   <= '0;
      alu_v2_o   <= '0;
      wb_valid_o <= 1'b0;
      wb_wa_o    <= '0;
      wb_src_o   <= '0;
      wb_data_o  <= '0;
    end else begin
      // NOP/undefined grants still advance the pointer but leave the datapath untouched.
      if (any_gnt) begin
        rr_ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      end
      if (start) begin
        alu_op_o <= gnt_op;
        alu_v1_o <= v1_arr[gnt_idx];
        alu_v2_o <= v2_arr[gnt_idx];
        wb_wa_o  <= wa_arr[gnt_idx];
        wb_src_o <= gnt_idx;
        cnt      <= CW'(op_lat(int'(gnt_op), ADD_LAT, MUL_LAT) - 1);
      end
      case (state)
        IDLE: begin
          if (start) state <= EXEC;
        end
        EXEC: begin
          if (cnt == '0) begin
            wb_data_o  <= alu_result_i;
            wb_valid_o <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (wb_ready_i) begin
            wb_valid_o <= 1'b0;
            state      <= start ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v_alu_sched.sv
// Self-checking bench for v_alu_sched: table vectors, directed corner sequences and a randomized
// run scored against a transaction-level model (round-robin pick, lane arithmetic, latency).
module tb_v_alu_sched;
  import v_alu_pkg::*;

  localparam int NREQ = 3, OW = 5, DW = 256, AW = 5, ADD_LAT = 1, MUL_LAT = 2;
  localparam int SW = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*OW-1:0] req_op;
  logic [NREQ*DW-1:0] req_v1, req_v2;
  logic [NREQ*AW-1:0] req_wa;
  logic [OW-1:0]      alu_op;
  logic [DW-1:0]      alu_v1, alu_v2, alu_result;
  logic               wb_valid, wb_ready;
  logic [AW-1:0]      wb_wa;
  logic [SW-1:0]      wb_src;
  logic [DW-1:0]      wb_data;
  logic               busy;

  logic [OW-1:0] s_op [NREQ];
  logic [DW-1:0] s_v1 [NREQ];
  logic [DW-1:0] s_v2 [NREQ];
  logic [AW-1:0] s_wa [NREQ];

  always #5 clk = ~clk;

  v_alu_sched #(
    .NREQ(NREQ), .VALUOP_DW(OW), .VREG_DW(DW), .VREG_AW(AW), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_v1_i(req_v1), .req_v2_i(req_v2), .req_wa_i(req_wa),
    .alu_op_o(alu_op), .alu_v1_o(alu_v1), .alu_v2_o(alu_v2), .alu_result_i(alu_result),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_wa_o(wb_wa), .wb_src_o(wb_src),
    .wb_data_o(wb_data), .busy_o(busy)
  );

  always_comb begin
    req_op = '0;
    req_v1 = '0;
    req_v2 = '0;
    req_wa = '0;
    for (int s = 0; s < NREQ; s++) begin
      req_op[s*OW +: OW] = s_op[s];
      req_v1[s*DW +: DW] = s_v1[s];
      req_v2[s*DW +: DW] = s_v2[s];
      req_wa[s*AW +: AW] = s_wa[s];
    end
  end

  // External combinational ALU stand-in.
  always_comb begin
    alu_result = '0;
    for (int l = 0; l < 8; l++) begin
      if (alu_op == OW'(VALU_OP_VADD))
        alu_result[l*32 +: 32] = alu_v1[l*32 +: 32] + alu_v2[l*32 +: 32];
      else if (alu_op == OW'(VALU_OP_VMUL))
        alu_result[l*32 +: 32] = alu_v1[l*32 +: 32] * alu_v2[l*32 +: 32];
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_result(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    longint unsigned x, y, z;
    r = '0;
    for (int l = 0; l < 8; l++) begin
      x = longint'(a[l*32 +: 32]);
      y = longint'(b[l*32 +: 32]);
      z = (op == VALU_OP_VADD) ? (x + y) % 64'h1_0000_0000 : (x * y) % 64'h1_0000_0000;
      r[l*32 +: 32] = z[31:0];
    end
    return r;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] g);
    for (int k = 0; k < NREQ; k++)
      if (g[k]) return k;
    return -1;
  endfunction

  typedef struct {
    int            src;
    logic [AW-1:0] wa;
    logic [DW-1:0] data;
    int            lat;
    int            gcyc;
  } exp_t;

  exp_t expq[$];
  int   gnt_log[$];
  int   mptr = 0, cyc = 0, wb_count = 0;
  bit   head_seen = 0, sb_en = 0, rand_wb = 0;

  logic [NREQ-1:0] obs_gnt;
  logic            obs_wbv, obs_wbh, obs_busy;
  logic [DW-1:0]   obs_data;
  logic [AW-1:0]   obs_wa;
  logic [SW-1:0]   obs_src;

  task automatic score();
    bit   empty0;
    int   g, op;
    exp_t e;
    empty0 = (expq.size() == 0);
    chk("busy", int'(obs_busy), int'(!empty0));
    chk("gnt_onehot", int'($countones(obs_gnt) <= 1), 1);
    if (obs_wbv) begin
      if (empty0) chk("wb_spurious", int'(obs_wbv), 0);
      else if (!head_seen) begin
        chk("wb_latency", cyc - expq[0].gcyc, expq[0].lat + 1);
        head_seen = 1;
      end
    end
    if (obs_wbh && !empty0) begin
      e = expq.pop_front();
      head_seen = 0;
      chk("wb_wa", int'(obs_wa), int'(e.wa));
      chk("wb_src", int'(obs_src), e.src);
      chkv("wb_data", obs_data, e.data);
    end
    if (empty0 || obs_wbh) begin
      if (|req_valid) chk("gnt_taken", int'(|obs_gnt), 1);
    end else begin
      chk("gnt_blocked", int'(obs_gnt), 0);
    end
    if (|obs_gnt) begin
      g = onehot_idx(obs_gnt);
      chk("rr_order", g, rr_pick(req_valid, mptr));
      mptr = (g + 1) % NREQ;
      op = int'(s_op[g]);
      if (op == VALU_OP_VADD || op == VALU_OP_VMUL)
        expq.push_back('{g, s_wa[g], ref_result(op, s_v1[g], s_v2[g]),
                         (op == VALU_OP_VADD) ? ADD_LAT : MUL_LAT, cyc});
    end
  endtask

  // One clock: sample at negedge, score, then drop granted requests just after the edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    obs_gnt  = req_ready;
    obs_wbv  = wb_valid;
    obs_wbh  = wb_valid && wb_ready;
    obs_busy = busy;
    obs_data = wb_data;
    obs_wa   = wb_wa;
    obs_src  = wb_src;
    if (obs_wbh) wb_count++;
    if (|obs_gnt) gnt_log.push_back(onehot_idx(obs_gnt));
    if (sb_en) score();
    @(posedge clk);
    #1;
    for (int s = 0; s < NREQ; s++)
      if (obs_gnt[s]) req_valid[s] = 1'b0;
    if (rand_wb) wb_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    sb_en = 0;
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
    expq.delete();
    gnt_log.delete();
    mptr = 0;
    head_seen = 0;
    sb_en = 1;
  endtask

  task automatic set_slot(input int s, input logic [OW-1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [AW-1:0] wa);
    s_op[s] = op;
    s_v1[s] = a;
    s_v2[s] = b;
    s_wa[s] = wa;
    req_valid[s] = 1'b1;
  endtask

  task automatic wait_gnt(input int s);
    bit ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      step();
      if (obs_gnt[s]) ok = 1;
    end
    chk("gnt_seen", int'(ok), 1);
  endtask

  task automatic wait_wb();
    bit ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      step();
      if (obs_wbv) ok = 1;
    end
    chk("wb_seen", int'(ok), 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      step();
      if (req_valid == '0 && expq.size() == 0) ok = 1;
    end
    chk("drained", int'(ok), 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_alu_op"}, int'(alu_op), 0);
    chkv({tag, "_alu_v1"}, alu_v1, '0);
    chkv({tag, "_alu_v2"}, alu_v2, '0);
    chk({tag, "_wb_valid"}, int'(wb_valid), 0);
    chkv({tag, "_wb_data"}, wb_data, '0);
    chk({tag, "_wb_wa"}, int'(wb_wa), 0);
    chk({tag, "_wb_src"}, int'(wb_src), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  typedef struct {
    int          slot;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [4:0]  wa;
    logic [31:0] exp_lane;
    int          exp_lat;
  } vec_t;

  vec_t vt[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc, w0;
    logic [DW-1:0] held;
    vt[0] = '{0, 5'd1, 32'd1,          32'd2,          5'd5,  32'd3,          2};
    vt[1] = '{1, 5'd2, 32'd3,          32'd4,          5'd9,  32'd12,         3};
    vt[2] = '{2, 5'd1, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'd0,          2};
    vt[3] = '{0, 5'd2, 32'h0001_0000,  32'h0001_0000,  5'd0,  32'd0,          3};
    vt[4] = '{1, 5'd2, 32'hFFFF_FFFF,  32'd2,          5'd17, 32'hFFFF_FFFE,  3};
    vt[5] = '{2, 5'd1, 32'h8000_0000,  32'h7FFF_FFFF,  5'd3,  32'hFFFF_FFFF,  2};
    for (int s = 0; s < NREQ; s++) begin
      s_op[s] = '0; s_v1[s] = '0; s_v2[s] = '0; s_wa[s] = '0;
    end
    wb_ready = 1'b1;
    req_valid = '0;

    do_reset();
    check_reset_values("rst0");
    chk("rst0_ready", int'(req_ready), 0);

    // Table: single-slot ops with fixed expected lanes and latency.
    for (int i = 0; i < 6; i++) begin
      set_slot(vt[i].slot, vt[i].op, {8{vt[i].a}}, {8{vt[i].b}}, vt[i].wa);
      wait_gnt(vt[i].slot);
      gc = cyc;
      wait_wb();
      chk($sformatf("vec%0d_lat", i), cyc - gc, vt[i].exp_lat);
      chkv($sformatf("vec%0d_data", i), obs_data, {8{vt[i].exp_lane}});
      chk($sformatf("vec%0d_wa", i), int'(obs_wa), int'(vt[i].wa));
      chk($sformatf("vec%0d_src", i), int'(obs_src), vt[i].slot);
    end
    drain();

    // All three slots contend; slot0 re-requests right after its grant and must wait behind 1,2.
    do_reset();
    set_slot(0, 5'd1, {8{32'd10}}, {8{32'd1}}, 5'd1);
    set_slot(1, 5'd1, {8{32'd20}}, {8{32'd2}}, 5'd2);
    set_slot(2, 5'd1, {8{32'd30}}, {8{32'd3}}, 5'd3);
    for (int n = 0; n < 60 && gnt_log.size() < 4; n++) begin
      step();
      if (obs_gnt[0] && gnt_log.size() == 1) set_slot(0, 5'd1, {8{32'd40}}, {8{32'd4}}, 5'd4);
    end
    chk("rr_log_len", gnt_log.size(), 4);
    if (gnt_log.size() >= 4) begin
      chk("rr_g0", gnt_log[0], 0);
      chk("rr_g1", gnt_log[1], 1);
      chk("rr_g2", gnt_log[2], 2);
      chk("rr_g3", gnt_log[3], 0);
    end
    drain();

    // Backpressure in DONE, then handshake and regrant in the same cycle.
    do_reset();
    wb_ready = 1'b0;
    set_slot(0, 5'd1, {8{32'd5}}, {8{32'd6}}, 5'd7);
    wait_gnt(0);
    wait_wb();
    held = obs_data;
    set_slot(2, 5'd1, {8{32'd1}}, {8{32'd1}}, 5'd11);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("bp_valid", int'(obs_wbv), 1);
      chkv("bp_data", obs_data, held);
      chk("bp_wa", int'(obs_wa), 7);
      chk("bp_nogrant", int'(obs_gnt), 0);
    end
    wb_ready = 1'b1;
    step();
    chk("bp_handshake", int'(obs_wbh), 1);
    chk("bp_regrant", int'(obs_gnt), 4);
    step();
    chk("bp_valid_drop", int'(obs_wbv), 0);
    chk("bp_busy", int'(obs_busy), 1);
    drain();

    // NOP is granted and dropped; only the VADD writes back; pointer then sits at 2.
    do_reset();
    w0 = wb_count;
    set_slot(0, 5'd0, {8{32'd9}}, {8{32'd9}}, 5'd20);
    set_slot(1, 5'd1, {8{32'd7}}, {8{32'd8}}, 5'd21);
    step();
    chk("nop_gnt0", int'(obs_gnt), 1);
    step();
    chk("nop_gnt1", int'(obs_gnt), 2);
    wait_wb();
    chk("nop_wb_src", int'(obs_src), 1);
    for (int n = 0; n < 4; n++) step();
    chk("nop_wb_count", wb_count - w0, 1);
    set_slot(0, 5'd1, {8{32'd1}}, {8{32'd2}}, 5'd1);
    set_slot(2, 5'd1, {8{32'd3}}, {8{32'd4}}, 5'd2);
    step();
    chk("nop_ptr2", int'(obs_gnt), 4);
    drain();

    // Reset in the middle of a VMUL: op discarded, pointer back to 0.
    do_reset();
    set_slot(1, 5'd2, {8{32'd3}}, {8{32'd4}}, 5'd12);
    wait_gnt(1);
    w0 = wb_count;
    do_reset();
    check_reset_values("rst_exec");
    for (int n = 0; n < 6; n++) step();
    chk("rst_no_wb", wb_count - w0, 0);
    set_slot(0, 5'd1, {8{32'd1}}, {8{32'd1}}, 5'd1);
    set_slot(2, 5'd1, {8{32'd2}}, {8{32'd2}}, 5'd2);
    step();
    chk("rst_ptr0", int'(obs_gnt), 1);
    drain();

    // Randomized traffic with random writeback backpressure.
    do_reset();
    rand_wb = 1;
    for (int n = 0; n < 800; n++) begin
      for (int s = 0; s < NREQ; s++) begin
        if (!req_valid[s] && $urandom_range(0, 2) == 0) begin
          logic [OW-1:0] op;
          logic [DW-1:0] a, b;
          case ($urandom_range(0, 5))
            0:       op = 5'd0;
            1, 3:    op = 5'd1;
            2, 4:    op = 5'd2;
            default: op = 5'd7;
          endcase
          for (int l = 0; l < 8; l++) begin
            a[l*32 +: 32] = $urandom();
            b[l*32 +: 32] = $urandom();
          end
          set_slot(s, op, a, b, AW'($urandom_range(0, 31)));
        end
      end
      step();
    end
    rand_wb = 0;
    wb_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
